// File: rtl/peach_mem_arbiter_if.sv
// peach_mem_arbiter_if
//   Bundles the three buses around the unified-memory arbiter:
//     if_*  : instruction-fetch requester (req/addr in, gnt/rvalid/rdata out)
//     ls_*  : load/store requester (req/we/size/addr/wdata in,
//             gnt/rvalid/rdata/err out)
//     mem_* : synchronous-read BRAM port (en/we/addr/wdata out, rdata in)
//   modport master : the requesters plus the memory (the arbiter's environment)
//   modport slave  : the arbiter itself
interface peach_mem_arbiter_if #(
    parameter int MEM_AW = 12
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;
    logic              ls_err;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/peach_mem_arbiter.sv
// peach_mem_arbiter
//   Shares the single 4K x 32 program/data memory of the peach32 core between
//   instruction fetch and load/store. Round-robin between the two requesters,
//   one transaction at a time: grant (IDLE) -> memory access (ACCESS) ->
//   response (RESP). Misaligned or illegal-size load/stores are answered from
//   ERR without touching memory.
//   Ports:
//     clk   : clock, all state on the rising edge
//     reset : asynchronous, active-low
//     bus   : peach_mem_arbiter_if.slave (fetch, load/store and memory buses)

// One byte lane of the store path: decides whether this lane is written for the
// given size/offset and which byte of the right-aligned store data lands here.
module peach_mem_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  boff,
    input  logic [31:0] wdata,
    output logic        we,
    output logic [7:0]  wd
);
    localparam logic [1:0] LID = 2'(LANE);

    always_comb begin
        we = 1'b0;
        wd = 8'h00;
        case (size)
            2'b00: begin
                we = (boff == LID);
                wd = wdata[7:0];
            end
            2'b01: begin
                // half-word: boff[1] picks the upper or lower lane pair
                we = (boff[1] == LID[1]);
                wd = LID[0] ? wdata[15:8] : wdata[7:0];
            end
            default: begin
                // word (size 11 never reaches the memory)
                we = 1'b1;
                wd = wdata[8*LANE +: 8];
            end
        endcase
    end
endmodule

module peach_mem_arbiter #(
    parameter int MEM_AW = 12
) (
    input  logic           clk,
    input  logic           reset,
    peach_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;
    typedef enum logic {OWN_IF, OWN_LS} owner_e;

    typedef struct packed {
        owner_e      owner;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_e           state, state_nxt;
    owner_e           last_owner;
    req_t             cur, grant_req;
    logic             gnt_if, gnt_ls;
    logic             ls_misalign;
    logic [3:0]       lane_we;
    logic [3:0][7:0]  lane_wd;

    // Address bits above the memory are dropped on purpose (accesses wrap).
    logic unused_addr;
    assign unused_addr = ^cur.addr[31:MEM_AW+2];

    always_comb begin
        ls_misalign = 1'b0;
        case (bus.ls_size)
            2'b00:   ls_misalign = 1'b0;
            2'b01:   ls_misalign = bus.ls_addr[0];
            2'b10:   ls_misalign = |bus.ls_addr[1:0];
            default: ls_misalign = 1'b1;
        endcase
    end

    // Grant is combinational in IDLE. Gated by reset so a request held
    // through reset never shows a grant.
    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (state == IDLE && reset) begin
            if (bus.if_req && bus.ls_req) begin
                gnt_if = (last_owner == OWN_LS);
                gnt_ls = (last_owner == OWN_IF);
            end else begin
                gnt_if = bus.if_req;
                gnt_ls = bus.ls_req;
            end
        end
    end

    always_comb begin
        grant_req = '0;
        if (gnt_if) begin
            grant_req.owner = OWN_IF;
            grant_req.we    = 1'b0;
            grant_req.size  = 2'b10;
            grant_req.addr  = bus.if_addr;
            grant_req.wdata = 32'h0;
        end else begin
            grant_req.owner = OWN_LS;
            grant_req.we    = bus.ls_we;
            grant_req.size  = bus.ls_size;
            grant_req.addr  = bus.ls_addr;
            grant_req.wdata = bus.ls_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= OWN_LS;
            cur        <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_if || gnt_ls) begin
                cur        <= grant_req;
                last_owner <= gnt_if ? OWN_IF : OWN_LS;
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        peach_mem_lane #(.LANE(i)) u_lane (
            .size  (cur.size),
            .boff  (cur.addr[1:0]),
            .wdata (cur.wdata),
            .we    (lane_we[i]),
            .wd    (lane_wd[i])
        );
    end

    assign bus.if_gnt = gnt_if;
    assign bus.ls_gnt = gnt_ls;

    // Everything below decodes from state only, so an async reset forces all
    // memory strobes low at once and an in-flight store never commits.
    always_comb begin
        state_nxt     = state;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = 32'h0;
        bus.ls_rvalid = 1'b0;
        bus.ls_rdata  = 32'h0;
        bus.ls_err    = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                if (gnt_if)      state_nxt = ACCESS;
                else if (gnt_ls) state_nxt = ls_misalign ? ERR : ACCESS;
            end
            ACCESS: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = cur.addr[MEM_AW+1:2];
                if (cur.we) begin
                    bus.mem_we    = lane_we;
                    bus.mem_wdata = lane_wd;
                end
                state_nxt = RESP;
            end
            RESP: begin
                if (cur.owner == OWN_IF) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.mem_rdata;
                end else begin
                    bus.ls_rvalid = 1'b1;
                    if (!cur.we) bus.ls_rdata = bus.mem_rdata;
                end
                state_nxt = IDLE;
            end
            ERR: begin
                bus.ls_rvalid = 1'b1;
                bus.ls_err    = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_peach_mem_arbiter.sv
// tb_peach_mem_arbiter
//   Drives directed fetch and load/store transactions into peach_mem_arbiter
//   with a behavioural BRAM attached. A transaction-level model predicts, per
//   cycle, grants, memory strobes and responses; directed literal checks pin
//   the model on the hand-worked cases.
module tb_peach_mem_arbiter;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    peach_mem_arbiter_if #(.MEM_AW(AW)) bus();
    peach_mem_arbiter #(.MEM_AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h0000_0093 : 32'hA000_0000 + 32'(i);
    endfunction

    // Behavioural synchronous-read BRAM.
    logic [31:0] mem [4096];
    bit mem_loaded = 0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
            mem_loaded <= 1;
        end else if (bus.mem_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    logic [31:0] ref_mem [4096];
    int          cyc = 0;
    bit          a_v [8];
    bit          a_fetch [8];
    bit          a_store [8];
    logic [3:0]  a_we [8];
    logic [31:0] a_addr [8];
    logic [31:0] a_wd [8];
    bit          r_if [8];
    bit          r_ls [8];
    bit          r_err [8];
    logic [31:0] r_ifd [8];
    logic [31:0] r_lsd [8];
    bit          m_last_ls = 1;
    int          free_at = 0;

    always @(negedge clk) begin
        int s, n1, off, sz;
        bit g_if, g_ls, bad;
        logic [3:0] ewe;
        logic [31:0] ewd, w;
        if (cyc == 0) for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        s  = cyc % 8;
        n1 = (cyc + 1) % 8;
        if (!reset) begin
            chk("rst_ctrl", {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid,
                             bus.ls_err, bus.mem_en, bus.mem_we}, 32'h0);
            chk("rst_data", bus.mem_wdata | bus.if_rdata | bus.ls_rdata | 32'(bus.mem_addr), 32'h0);
            for (int i = 0; i < 8; i++) begin
                a_v[i] = 0; a_fetch[i] = 0; a_store[i] = 0; a_we[i] = 0; a_addr[i] = 0; a_wd[i] = 0;
                r_if[i] = 0; r_ls[i] = 0; r_err[i] = 0; r_ifd[i] = 0; r_lsd[i] = 0;
            end
            m_last_ls = 1;
            free_at   = 0;
        end else begin
            g_if = 0;
            g_ls = 0;
            if (cyc >= free_at) begin
                if (bus.if_req && bus.ls_req) begin
                    g_if = m_last_ls;
                    g_ls = !m_last_ls;
                end else begin
                    g_if = bus.if_req;
                    g_ls = bus.ls_req;
                end
            end
            chk("ctrl", {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.ls_err,
                         bus.mem_en, bus.mem_we},
                        {g_if, g_ls, r_if[s], r_ls[s], r_err[s], a_v[s], a_we[s]});
            chk("mem_addr", 32'(bus.mem_addr), a_addr[s]);
            chk("mem_wdata", bus.mem_wdata, a_wd[s]);
            chk("if_rdata", bus.if_rdata, r_ifd[s]);
            chk("ls_rdata", bus.ls_rdata, r_lsd[s]);
            // retire the memory access happening this cycle
            if (a_v[s]) begin
                w = ref_mem[a_addr[s]];
                if (a_fetch[s]) begin
                    r_if[n1] = 1; r_ifd[n1] = w;
                end else begin
                    r_ls[n1] = 1; r_lsd[n1] = a_store[s] ? 32'h0 : w;
                end
                if (a_store[s])
                    for (int b = 0; b < 4; b++)
                        if (a_we[s][b]) ref_mem[a_addr[s]][8*b +: 8] = a_wd[s][8*b +: 8];
            end
            a_v[s] = 0; a_fetch[s] = 0; a_store[s] = 0; a_we[s] = 0; a_addr[s] = 0; a_wd[s] = 0;
            r_if[s] = 0; r_ls[s] = 0; r_err[s] = 0; r_ifd[s] = 0; r_lsd[s] = 0;
            if (g_if) begin
                m_last_ls   = 0;
                free_at     = cyc + 3;
                a_v[n1]     = 1;
                a_fetch[n1] = 1;
                a_addr[n1]  = 32'(bus.if_addr[AW+1:2]);
            end
            if (g_ls) begin
                m_last_ls = 1;
                off = int'(bus.ls_addr % 4);
                sz  = int'(bus.ls_size);
                bad = (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
                if (bad) begin
                    r_ls[n1]  = 1;
                    r_err[n1] = 1;
                    free_at   = cyc + 2;
                end else begin
                    free_at    = cyc + 3;
                    a_v[n1]    = 1;
                    a_addr[n1] = 32'(bus.ls_addr[AW+1:2]);
                    if (bus.ls_we) begin
                        if (sz == 0) begin
                            ewe = 4'(1 << off);
                            ewd = 32'(bus.ls_wdata[7:0]) * 32'h0101_0101;
                        end else if (sz == 1) begin
                            ewe = (off >= 2) ? 4'hC : 4'h3;
                            ewd = 32'(bus.ls_wdata[15:0]) * 32'h0001_0001;
                        end else begin
                            ewe = 4'hF;
                            ewd = bus.ls_wdata;
                        end
                        a_store[n1] = 1;
                        a_we[n1]    = ewe;
                        a_wd[n1]    = ewd;
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic wait_gnt(input bit is_ls, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_ls ? bus.ls_gnt : bus.if_gnt) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 32'h0, 32'h1);
    endtask

    // Both issue tasks return one cycle after the grant (req already dropped).
    task automatic issue_if(input logic [31:0] addr);
        bit ok;
        @(posedge clk); #1;
        bus.if_addr = addr;
        bus.if_req  = 1;
        wait_gnt(0, ok);
        @(posedge clk); #1;
        bus.if_req = 0;
    endtask

    task automatic issue_ls(input bit we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
        bit ok;
        @(posedge clk); #1;
        bus.ls_we    = we;
        bus.ls_size  = size;
        bus.ls_addr  = addr;
        bus.ls_wdata = wdata;
        bus.ls_req   = 1;
        wait_gnt(1, ok);
        @(posedge clk); #1;
        bus.ls_req = 0;
    endtask

    initial begin
        int  gcyc [$];
        bit  gls [$];
        bit  ok;
        int  rv;
        bus.if_req = 0; bus.if_addr = 0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
        repeat (3) @(posedge clk);

        // both requesters held from reset: strict alternation, fetch first
        #1;
        bus.if_addr = 32'h8;
        bus.if_req  = 1;
        bus.ls_we = 0; bus.ls_size = 2'b10; bus.ls_addr = 32'hC;
        bus.ls_req  = 1;
        @(posedge clk); #1;
        reset = 1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.if_gnt) begin gcyc.push_back(i); gls.push_back(0); end
            if (bus.ls_gnt) begin gcyc.push_back(i); gls.push_back(1); end
        end
        @(posedge clk); #1;
        bus.if_req = 0; bus.ls_req = 0;
        repeat (4) @(negedge clk);
        chk("alt_count", 32'(gcyc.size()), 32'd5);
        if (gcyc.size() >= 4) begin
            chk("alt_first_t", 32'(gcyc[0]), 32'd0);
            for (int k = 0; k < 4; k++) chk("alt_order", 32'(gls[k]), 32'(k % 2));
            for (int k = 0; k < 3; k++) chk("alt_gap", 32'(gcyc[k+1] - gcyc[k]), 32'd3);
        end

        // single fetch of word 2
        issue_if(32'h0000_0008);
        @(negedge clk);
        chk("f_access", {bus.mem_en, bus.mem_we, 20'(bus.mem_addr)}, {1'b1, 4'b0000, 20'd2});
        @(negedge clk);
        chk("f_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 2'b10);
        chk("f_rdata", bus.if_rdata, 32'h0000_0093);

        // SB to byte 3 of word 4
        issue_ls(1, 2'b00, 32'h0000_0013, 32'h1234_56AB);
        @(negedge clk);
        chk("sb_we", {bus.mem_en, bus.mem_we, 20'(bus.mem_addr)}, {1'b1, 4'b1000, 20'd4});
        chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        @(negedge clk);
        chk("sb_resp", {bus.ls_rvalid, bus.ls_err}, 2'b10);
        chk("sb_rdata", bus.ls_rdata, 32'h0);

        // SH to the upper half of word 4
        issue_ls(1, 2'b01, 32'h0000_0012, 32'h0000_BEEF);
        @(negedge clk);
        chk("sh_we", {bus.mem_en, bus.mem_we}, 5'b1_1100);
        chk("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        @(negedge clk);
        chk("sh_resp", {bus.ls_rvalid, bus.ls_err}, 2'b10);

        // LW word 4 returns the merged word
        issue_ls(0, 2'b10, 32'h0000_0010, 32'h0);
        @(negedge clk);
        chk("lw_access", {bus.mem_en, bus.mem_we}, 5'b1_0000);
        @(negedge clk);
        chk("lw_rdata", bus.ls_rdata, 32'hBEEF_0004);

        // misaligned LW / SH and illegal size: immediate error, no memory access
        issue_ls(0, 2'b10, 32'h0000_0006, 32'h0);
        @(negedge clk);
        chk("lw_mis", {bus.ls_rvalid, bus.ls_err, bus.mem_en}, 3'b110);
        issue_ls(1, 2'b01, 32'h0000_0001, 32'h0000_5555);
        @(negedge clk);
        chk("sh_mis", {bus.ls_rvalid, bus.ls_err, bus.mem_en, bus.mem_we}, 7'b110_0000);
        chk("sh_mis_rdata", bus.ls_rdata, 32'h0);
        issue_ls(0, 2'b11, 32'h0000_0000, 32'h0);
        @(negedge clk);
        chk("sz3_err", {bus.ls_rvalid, bus.ls_err, bus.mem_en}, 3'b110);

        // fetch above the memory wraps
        issue_if(32'h0000_4004);
        @(negedge clk);
        chk("wrap_addr", 32'(bus.mem_addr), 32'd1);
        @(negedge clk);
        chk("wrap_rdata", bus.if_rdata, 32'hA000_0001);

        // reset during the ACCESS of a SW to word 5
        @(posedge clk); #1;
        bus.ls_we = 1; bus.ls_size = 2'b10; bus.ls_addr = 32'h14; bus.ls_wdata = 32'hDEAD_BEEF;
        bus.ls_req = 1;
        wait_gnt(1, ok);
        @(posedge clk); #1;
        bus.ls_req = 0;
        reset = 0;
        #1;
        chk("abort_ctrl", {bus.mem_en, bus.mem_we, bus.ls_rvalid, bus.ls_gnt, bus.if_gnt}, 32'h0);
        chk("abort_data", bus.mem_wdata | 32'(bus.mem_addr), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        rv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ls_rvalid || bus.if_rvalid) rv++;
        end
        chk("abort_no_rvalid", 32'(rv), 32'd0);
        @(posedge clk); #1;
        bus.if_addr = 32'h0; bus.if_req = 1;
        bus.ls_we = 0; bus.ls_size = 2'b10; bus.ls_addr = 32'h14; bus.ls_req = 1;
        @(negedge clk);
        chk("post_rst_conflict", {bus.if_gnt, bus.ls_gnt}, 2'b10);
        @(posedge clk); #1;
        bus.if_req = 0;
        wait_gnt(1, ok);
        @(posedge clk); #1;
        bus.ls_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("w5_load", bus.ls_rdata, 32'hA000_0005);
        repeat (3) @(negedge clk);
        chk("w5_mem", mem[5], 32'hA000_0005);
        chk("w4_mem", mem[4], 32'hBEEF_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/peach_mem_arbiter.md
# peach_mem_arbiter

Two-port arbiter that shares the single 4K×32 unified program/data memory of the peach32 multi-cycle core between the instruction-fetch requester (FETCH state) and the load/store requester (LOAD/STORE states). It serializes requests with round-robin priority, drives a synchronous-read BRAM port, generates byte-lane write enables for SB/SH/SW, and routes read data back to the owning requester. Misaligned load/store accesses are rejected without touching memory.

## Interface
- MEM_AW, 12: word-address width of the memory (4096 words).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  one-cycle grant to fetch.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  instruction word; 0 when if_rvalid low.
- ls_req  in  1  load/store request; held with ls_* stable until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data, right-aligned.
- ls_gnt  out  1  one-cycle grant to load/store.
- ls_rvalid  out  1  one-cycle completion pulse (loads and stores).
- ls_rdata  out  32  raw aligned memory word (loads); 0 for stores, errors, or when ls_rvalid low.
- ls_err  out  1  valid with ls_rvalid; 1 = misaligned/illegal size.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte-lane write enables.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  memory read data, valid one cycle after mem_en.

## Operation
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: if exactly one req high, grant it; if both high, grant the requester not granted last (last_owner register, reset value LS, so fetch wins the first conflict). Grant is combinational in IDLE; the request (owner, we, size, addr, wdata) is latched on the same edge. The next state is ACCESS, or ERR for a misaligned LS request. With no request, remain in IDLE.
- Misaligned: size 01 with addr[0]=1; size 10 with addr[1:0]≠0; size 11 always. Fetch requests are never checked. addr[1:0] is ignored for fetches.
- ACCESS: mem_en=1, mem_addr=addr[MEM_AW+1:2]. Address bits above MEM_AW+1 are ignored (wrap). For a load or fetch, mem_we=0000. For a store:
  - byte: mem_we=0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - half: mem_we = addr[1] ? 1100 : 0011, mem_wdata={2{wdata[15:0]}}.
  - word: mem_we=1111, mem_wdata=wdata.
  - The next state is always RESP.
- RESP: pulse the owner's rvalid. For a read, the owner's rdata is mem_rdata. Go to IDLE.
- ERR: ls_rvalid=1, ls_err=1, ls_rdata=0, mem_en=0. Go to IDLE.
- last_owner updates on every grant, including error grants.
- Requests arriving in ACCESS/RESP/ERR are not granted. Requesters hold req until gnt, then have at most one outstanding transaction.
- Sign/zero extension and lane selection of load data are the core's job; the arbiter returns the raw word.

## Timing
- Normal transaction: gnt in cycle T, memory access in T+1, rvalid in T+2, next grant possible in T+3.
- Error transaction: gnt in T, ls_rvalid+ls_err in T+1.
- Back-to-back requests from both sides alternate strictly (F, LS, F, LS...).
- mem_* are driven to 0 outside ACCESS. mem_wdata=0 for reads.
- Reset (async, any state) outputs: all gnt/rvalid/err=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. State returns to IDLE and last_owner to LS.
- A reset asserted during ACCESS drops mem_we immediately, so no write commits. The aborted transaction produces no rvalid after reset release.

## Test plan
- Single fetch, addr 0x0000_0008, memory word 2 = 0x0000_0093 -> if_gnt at T, mem_en with mem_addr=2 at T+1, if_rvalid with if_rdata=0x0000_0093 at T+2.
- SB, addr 0x0000_0013, wdata 0x1234_56AB -> mem_we=1000, mem_wdata=0xABAB_ABAB, mem_addr=4. SH at 0x12, wdata 0xBEEF -> mem_we=1100, mem_wdata=0xBEEF_BEEF. Each gives ls_rvalid with ls_err=0 and ls_rdata=0.
- Both req held continuously from reset -> grant order F, LS, F, LS. Each grant is 3 cycles apart, and each rvalid goes only to its owner.
- LW at 0x0000_0006, and SH at 0x0000_0001 -> each gets ls_gnt then ls_rvalid=1, ls_err=1 one cycle later. mem_en never asserts and memory is unchanged.
- Fetch at 0x0000_4004 with MEM_AW=12 -> mem_addr=1 (wrap).
- Assert reset during ACCESS of SW 0xDEADBEEF to word 5 -> all outputs 0 immediately, word 5 unchanged, no rvalid after release, and the first post-reset conflict grants fetch.
